// File: rtl/random_bytes_pkg.sv
// rtl/random_bytes_pkg.sv - shared types, shift constants and xorshift32 step for random_bytes
package random_bytes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int XS_SHIFT_A = 13;
    localparam int XS_SHIFT_B = 17;
    localparam int XS_SHIFT_C = 5;

    function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << XS_SHIFT_A);
        t = t ^ (t >> XS_SHIFT_B);
        t = t ^ (t << XS_SHIFT_C);
        return t;
    endfunction

endpackage

// File: rtl/random_bytes_if.sv
// rtl/random_bytes_if.sv - start/result handshake bundle for random_bytes
interface random_bytes_if #(
    parameter int IN_LEN = 32
) ();

    logic                  start;
    logic [IN_LEN*8-1:0]   zeta_out;
    logic                  random_done;

    modport master (
        output start,
        input  zeta_out,
        input  random_done
    );

    modport slave (
        input  start,
        output zeta_out,
        output random_done
    );

endinterface

// File: rtl/random_bytes_xorshift32_core.sv
// rtl/random_bytes_xorshift32_core.sv - xorshift32 state register with seed load and step enable
module xorshift32_core
    import random_bytes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        en,
    output logic [31:0] next_word
);

    logic [31:0] state_q;

    // The consumer wants the freshly advanced value on the same edge it is stored.
    assign next_word = xorshift32_next(state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else if (en) begin
            state_q <= next_word;
        end
    end

endmodule

// File: rtl/random_bytes.sv
// rtl/random_bytes.sv - fills an IN_LEN-byte register from a seeded xorshift32 PRNG on start
module random_bytes
    import random_bytes_pkg::*;
#(
    parameter int          IN_LEN = 32,
    parameter logic [31:0] SEED   = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    random_bytes_if.slave        bus
);

    localparam int          W        = (IN_LEN + 3) / 4;
    localparam int          CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [IN_LEN*8-1:0] zeta_q;
    logic                gen_en;
    logic [31:0]         next_word;

    xorshift32_core u_core (
        .clk       (clk),
        .rst       (rst),
        .seed      (SEED_EFF),
        .en        (gen_en),
        .next_word (next_word)
    );

    always_comb begin
        state_d = state_q;
        gen_en  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = GEN;
            GEN: begin
                gen_en = 1'b1;
                if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
            end
            DONE: if (bus.start) state_d = GEN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == GEN) ? cnt_q + 1'b1 : '0;
        end
    end

    // Bytes past IN_LEN in the last word simply have no destination and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            zeta_q <= '0;
        end else if (gen_en) begin
            for (int i = 0; i < IN_LEN; i++) begin
                if (cnt_q == CNT_W'(i / 4)) begin
                    zeta_q[i*8 +: 8] <= next_word[(i % 4)*8 +: 8];
                end
            end
        end
    end

    assign bus.zeta_out    = zeta_q;
    assign bus.random_done = (state_q == DONE);

endmodule

// File: tb/tb_random_bytes.sv
// tb/tb_random_bytes.sv - directed self-checking bench for random_bytes
module tb_random_bytes;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    random_bytes_if #(.IN_LEN(32)) bus_a ();
    random_bytes_if #(.IN_LEN(6))  bus_b ();
    random_bytes_if #(.IN_LEN(32)) bus_c ();

    random_bytes #(.IN_LEN(32), .SEED(32'h1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    random_bytes #(.IN_LEN(6),  .SEED(32'h1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    random_bytes #(.IN_LEN(32), .SEED(32'h0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic [255:0] exp_blk1, exp_blk2, exp_blk3;
    logic [31:0]  model_st;
    int           lat_a, lat_b, lat_c;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic make_block(inout logic [31:0] s, output logic [255:0] blk);
        for (int k = 0; k < 8; k++) begin
            s = xs(s);
            blk[k*32 +: 32] = s;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_a.zeta_out !== 256'h0) begin errors++; $display("FAIL reset_zeta_a got=%h want=0", bus_a.zeta_out); end
        checks++; if (bus_a.random_done !== 1'b0) begin errors++; $display("FAIL reset_done_a got=%b want=0", bus_a.random_done); end
        checks++; if (bus_b.zeta_out !== 48'h0) begin errors++; $display("FAIL reset_zeta_b got=%h want=0", bus_b.zeta_out); end
        checks++; if (bus_b.random_done !== 1'b0) begin errors++; $display("FAIL reset_done_b got=%b want=0", bus_b.random_done); end
        checks++; if (bus_c.zeta_out !== 256'h0) begin errors++; $display("FAIL reset_zeta_c got=%h want=0", bus_c.zeta_out); end
    endtask

    task automatic test_first_block();
        bus_a.start = 1'b1; bus_b.start = 1'b1; bus_c.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
        lat_a = -1; lat_b = -1; lat_c = -1;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(posedge clk);
            if (k > 1) #1;
            if (k == 1) begin @(posedge clk); #1; end
            if (lat_a < 0 && bus_a.random_done) lat_a = k;
            if (lat_b < 0 && bus_b.random_done) lat_b = k;
            if (lat_c < 0 && bus_c.random_done) lat_c = k;
        end
        checks++; if (lat_a != 8) begin errors++; $display("FAIL first_latency_a got=%0d want=8", lat_a); end
        checks++; if (lat_b != 2) begin errors++; $display("FAIL first_latency_b got=%0d want=2", lat_b); end
        checks++; if (lat_c != 8) begin errors++; $display("FAIL first_latency_c got=%0d want=8", lat_c); end
        checks++; if (bus_a.zeta_out[31:0] !== 32'h00042021) begin errors++; $display("FAIL first_word0 got=%h want=00042021", bus_a.zeta_out[31:0]); end
        checks++; if (bus_a.zeta_out[63:32] !== 32'h04080601) begin errors++; $display("FAIL first_word1 got=%h want=04080601", bus_a.zeta_out[63:32]); end
        checks++; if (bus_a.zeta_out !== exp_blk1) begin errors++; $display("FAIL first_block_a got=%h want=%h", bus_a.zeta_out, exp_blk1); end
        checks++; if (bus_b.zeta_out !== 48'h0601_00042021) begin errors++; $display("FAIL short_block_b got=%h want=060100042021", bus_b.zeta_out); end
        checks++; if (bus_c.zeta_out !== exp_blk1) begin errors++; $display("FAIL seed0_block_c got=%h want=%h", bus_c.zeta_out, exp_blk1); end
        checks++; if (bus_a.random_done !== 1'b1) begin errors++; $display("FAIL done_held_a got=%b want=1", bus_a.random_done); end
    endtask

    task automatic test_second_block();
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        checks++; if (bus_a.random_done !== 1'b0) begin errors++; $display("FAIL second_done_drop got=%b want=0", bus_a.random_done); end
        lat_a = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (lat_a < 0 && bus_a.random_done) lat_a = k;
        end
        checks++; if (lat_a != 8) begin errors++; $display("FAIL second_latency got=%0d want=8", lat_a); end
        checks++; if (bus_a.zeta_out[31:0] !== exp_blk2[31:0]) begin errors++; $display("FAIL second_word0 got=%h want=%h", bus_a.zeta_out[31:0], exp_blk2[31:0]); end
        checks++; if (bus_a.zeta_out !== exp_blk2) begin errors++; $display("FAIL second_block got=%h want=%h", bus_a.zeta_out, exp_blk2); end
        checks++; if (bus_a.zeta_out === exp_blk1) begin errors++; $display("FAIL second_differs got=%h want_not=%h", bus_a.zeta_out, exp_blk1); end
    endtask

    task automatic test_start_during_gen();
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        lat_a = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (lat_a < 0 && bus_a.random_done) lat_a = k;
            bus_a.start = (k >= 2 && k <= 4);
        end
        bus_a.start = 1'b0;
        checks++; if (lat_a != 8) begin errors++; $display("FAIL gen_start_latency got=%0d want=8", lat_a); end
        checks++; if (bus_a.zeta_out !== exp_blk3) begin errors++; $display("FAIL gen_start_block got=%h want=%h", bus_a.zeta_out, exp_blk3); end
    endtask

    task automatic test_reset_mid_gen();
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (bus_a.zeta_out !== 256'h0) begin errors++; $display("FAIL midrst_zeta_a got=%h want=0", bus_a.zeta_out); end
        checks++; if (bus_a.random_done !== 1'b0) begin errors++; $display("FAIL midrst_done_a got=%b want=0", bus_a.random_done); end
        checks++; if (bus_c.zeta_out !== 256'h0) begin errors++; $display("FAIL midrst_zeta_c got=%h want=0", bus_c.zeta_out); end
        bus_a.start = 1'b1; bus_c.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0; bus_c.start = 1'b0;
        lat_a = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (lat_a < 0 && bus_a.random_done) lat_a = k;
        end
        checks++; if (lat_a != 8) begin errors++; $display("FAIL midrst_latency got=%0d want=8", lat_a); end
        checks++; if (bus_a.zeta_out !== exp_blk1) begin errors++; $display("FAIL midrst_block_a got=%h want=%h", bus_a.zeta_out, exp_blk1); end
        checks++; if (bus_c.zeta_out !== exp_blk1) begin errors++; $display("FAIL midrst_block_c got=%h want=%h", bus_c.zeta_out, exp_blk1); end
    endtask

    initial begin
        model_st = 32'h1;
        make_block(model_st, exp_blk1);
        make_block(model_st, exp_blk2);
        make_block(model_st, exp_blk3);
        test_reset();
        test_first_block();
        test_second_block();
        test_start_during_gen();
        test_reset_mid_gen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
